// File: rtl/alt_xcvr_rcfg_resp_pkg.sv
// Shared types and constants for the reconfiguration Avalon-MM responder and
// streamer profile ROM entries.
package alt_xcvr_rcfg_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ACK
  } resp_state_e;

  localparam int unsigned DEF_ADDR_WIDTH  = 10;
  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned REG_WIDTH       = 8;
  localparam int unsigned DEF_NUM_REGS    = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

  // Profile ROM entry layout: {addr[25:16], mask[15:8], data[7:0]}
  localparam int unsigned ROM_ADDR_MSB = 25;
  localparam int unsigned ROM_ADDR_LSB = 16;
  localparam int unsigned ROM_MASK_MSB = 15;
  localparam int unsigned ROM_MASK_LSB = 8;
  localparam int unsigned ROM_DATA_MSB = 7;
  localparam int unsigned ROM_DATA_LSB = 0;
  localparam logic [25:0] ROM_END_MARKER = 26'h3FFFFFF;

endpackage

// File: rtl/alt_xcvr_rcfg_regfile.sv
// Register array for the responder: synchronous clear, one write port and one
// combinational read port.
module alt_xcvr_rcfg_regfile #(
  parameter int unsigned NUM_REGS  = 1024,
  parameter int unsigned REG_WIDTH = 8,
  parameter int unsigned IDX_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [REG_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic [REG_WIDTH-1:0] rdata
);

  logic [REG_WIDTH-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alt_xcvr_rcfg_avmm_responder.sv
// Avalon-MM responder for the reconfiguration streamer: wait-state FSM,
// write statistics and sticky protocol-error detection around the register file.
module alt_xcvr_rcfg_avmm_responder
  import alt_xcvr_rcfg_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = alt_xcvr_rcfg_resp_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = alt_xcvr_rcfg_resp_pkg::DEF_DATA_WIDTH,
  parameter int unsigned REG_WIDTH   = alt_xcvr_rcfg_resp_pkg::REG_WIDTH,
  parameter int unsigned NUM_REGS    = alt_xcvr_rcfg_resp_pkg::DEF_NUM_REGS,
  parameter int unsigned WAIT_CYCLES = alt_xcvr_rcfg_resp_pkg::DEF_WAIT_CYCLES
) (
  input  logic                  reconfig_clk,
  input  logic                  reconfig_reset,
  input  logic [ADDR_WIDTH-1:0] reconfig_address,
  input  logic                  reconfig_write,
  input  logic [DATA_WIDTH-1:0] reconfig_writedata,
  input  logic                  reconfig_read,
  output logic [DATA_WIDTH-1:0] reconfig_readdata,
  output logic                  reconfig_waitrequest,
  output logic [15:0]           wr_count,
  output logic [ADDR_WIDTH-1:0] last_wr_addr,
  output logic                  prot_err
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  resp_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
  logic [15:0]           wr_count_q, wr_count_d;
  logic [ADDR_WIDTH-1:0] last_wr_addr_q, last_wr_addr_d;
  logic                  prot_err_q, prot_err_d;

  logic                  enter_ack;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_wr;
  logic                  cur_in_range;
  logic                  req_changed;
  logic                  rf_we;
  logic [REG_WIDTH-1:0]  rf_rdata;
  logic                  unused_wdata_hi;

  // In IDLE the live bus is the access; afterwards the latched copy is authoritative.
  assign cur_addr     = (state_q == ST_IDLE) ? reconfig_address : addr_q;
  assign cur_wr       = (state_q == ST_IDLE) ? reconfig_write : wr_q;
  assign cur_in_range = 32'(cur_addr) < NUM_REGS;
  assign req_changed  = (reconfig_address != addr_q) || (reconfig_read != rd_q) ||
                        (reconfig_write != wr_q);
  assign rf_we        = (state_q == ST_ACK) && wr_q && cur_in_range;
  assign unused_wdata_hi = ^reconfig_writedata[DATA_WIDTH-1:REG_WIDTH];

  alt_xcvr_rcfg_regfile #(
    .NUM_REGS (NUM_REGS),
    .REG_WIDTH(REG_WIDTH),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk  (reconfig_clk),
    .rst  (reconfig_reset),
    .we   (rf_we),
    .waddr(cur_addr[IDX_W-1:0]),
    .wdata(wdata_q),
    .raddr(cur_addr[IDX_W-1:0]),
    .rdata(rf_rdata)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    readdata_d     = readdata_q;
    wr_count_d     = wr_count_q;
    last_wr_addr_d = last_wr_addr_q;
    prot_err_d     = prot_err_q;
    enter_ack      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (reconfig_read || reconfig_write) begin
          addr_d  = reconfig_address;
          wdata_d = reconfig_writedata[REG_WIDTH-1:0];
          rd_d    = reconfig_read;
          wr_d    = reconfig_write;
          cnt_d   = CNT_LOAD;
          if ((reconfig_read && reconfig_write) || !cur_in_range) prot_err_d = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (!reconfig_read && !reconfig_write) begin
          state_d    = ST_IDLE;
          prot_err_d = 1'b1;
        end else begin
          if (req_changed) prot_err_d = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end
        end
      end
      ST_ACK: begin
        if (req_changed) prot_err_d = 1'b1;
        state_d = ST_IDLE;
        if (wr_q && cur_in_range) begin
          wr_count_d     = (wr_count_q == '1) ? wr_count_q : wr_count_q + 1'b1;
          last_wr_addr_d = addr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Read data is captured on entry to ACK so it is stable for the whole ACK cycle.
    if (enter_ack && !cur_wr) begin
      readdata_d = cur_in_range ? DATA_WIDTH'(rf_rdata) : '0;
    end
  end

  always_ff @(posedge reconfig_clk) begin
    if (reconfig_reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      readdata_q     <= '0;
      wr_count_q     <= '0;
      last_wr_addr_q <= '0;
      prot_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      readdata_q     <= readdata_d;
      wr_count_q     <= wr_count_d;
      last_wr_addr_q <= last_wr_addr_d;
      prot_err_q     <= prot_err_d;
    end
  end

  assign reconfig_waitrequest = (state_q != ST_ACK);
  assign reconfig_readdata    = readdata_q;
  assign wr_count             = wr_count_q;
  assign last_wr_addr         = last_wr_addr_q;
  assign prot_err             = prot_err_q;

endmodule

// File: tb/tb_alt_xcvr_rcfg_avmm_responder.sv
// Directed bench for the reconfiguration responder: default instance (2 wait
// states, 1024 regs) plus a zero-wait, 512-register instance.
module tb_alt_xcvr_rcfg_avmm_responder;
  import alt_xcvr_rcfg_resp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  addr, a0;
  logic        wr, rd, w0, r0;
  logic [31:0] wd, wd0, rdata, rdata0;
  logic        wreq, wreq0, perr, perr0;
  logic [15:0] wrc, wrc0;
  logic [9:0]  lwa, lwa0;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  logic [25:0] rom [0:5];
  logic [31:0] rv;
  int          waits;

  alt_xcvr_rcfg_avmm_responder dut (
    .reconfig_clk(clk), .reconfig_reset(rst), .reconfig_address(addr),
    .reconfig_write(wr), .reconfig_writedata(wd), .reconfig_read(rd),
    .reconfig_readdata(rdata), .reconfig_waitrequest(wreq), .wr_count(wrc),
    .last_wr_addr(lwa), .prot_err(perr)
  );

  alt_xcvr_rcfg_avmm_responder #(.WAIT_CYCLES(0), .NUM_REGS(512)) dut0 (
    .reconfig_clk(clk), .reconfig_reset(rst), .reconfig_address(a0),
    .reconfig_write(w0), .reconfig_writedata(wd0), .reconfig_read(r0),
    .reconfig_readdata(rdata0), .reconfig_waitrequest(wreq0), .wr_count(wrc0),
    .last_wr_addr(lwa0), .prot_err(perr0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full Avalon access on the default instance; optional address change after one cycle.
  task automatic access(input logic is_rd, input logic is_wr, input logic [9:0] a,
                        input logic [31:0] d, input logic chg, input logic [9:0] a2,
                        output logic [31:0] rdv, output int nw);
    addr = a; wd = d; rd = is_rd; wr = is_wr; nw = 0;
    while (wreq && nw < 50) begin
      @(posedge clk); #1;
      nw++;
      if (chg && nw == 1) addr = a2;
    end
    if (nw >= 50) chk("handshake_timeout", {31'b0, wreq}, 32'd0);
    rdv = rdata;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic access0(input logic is_rd, input logic is_wr, input logic [9:0] a,
                         input logic [31:0] d, output logic [31:0] rdv);
    int nw;
    a0 = a; wd0 = d; r0 = is_rd; w0 = is_wr; nw = 0;
    while (wreq0 && nw < 50) begin
      @(posedge clk); #1;
      nw++;
    end
    if (nw >= 50) chk("handshake0_timeout", {31'b0, wreq0}, 32'd0);
    rdv = rdata0;
    @(posedge clk); #1;
    r0 = 1'b0; w0 = 1'b0;
  endtask

  task automatic stream_profile(input int start);
    logic [25:0] ent;
    logic [9:0]  ra;
    logic [7:0]  m, dv, old;
    logic [31:0] r;
    int          nw;
    for (int i = start; i < 6 && rom[i] != ROM_END_MARKER; i++) begin
      ent = rom[i];
      ra  = ent[ROM_ADDR_MSB:ROM_ADDR_LSB];
      m   = ent[ROM_MASK_MSB:ROM_MASK_LSB];
      dv  = ent[ROM_DATA_MSB:ROM_DATA_LSB];
      access(1'b1, 1'b0, ra, 32'd0, 1'b0, 10'd0, r, nw);
      old = r[7:0];
      access(1'b0, 1'b1, ra, {24'd0, (old & ~m) | (dv & m)}, 1'b0, 10'd0, r, nw);
    end
  endtask

  initial begin
    rom[0] = {10'h135, 8'h0C, 8'h00};
    rom[1] = {10'h13A, 8'h38, 8'h28};
    rom[2] = ROM_END_MARKER;
    rom[3] = {10'h135, 8'h0C, 8'h0C};
    rom[4] = {10'h13A, 8'h38, 8'h20};
    rom[5] = ROM_END_MARKER;

    rst = 1'b1; addr = '0; wr = 1'b0; rd = 1'b0; wd = '0;
    a0 = '0; w0 = 1'b0; r0 = 1'b0; wd0 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_waitreq", {31'b0, wreq}, 32'd1);
    chk("rst_readdata", rdata, 32'd0);
    chk("rst_wr_count", {16'b0, wrc}, 32'd0);
    chk("rst_last_wr_addr", {22'b0, lwa}, 32'd0);
    chk("rst_prot_err", {31'b0, perr}, 32'd0);
    chk("rst_waitreq0", {31'b0, wreq0}, 32'd1);

    access(1'b1, 1'b0, 10'h135, 32'd0, 1'b0, 10'd0, rv, waits);
    chk("rd135_waits", 32'(waits), 32'd3);
    chk("rd135_data", rv, 32'h0);
    chk("rd135_prot_err", {31'b0, perr}, 32'd0);

    access(1'b0, 1'b1, 10'h13A, 32'hABCDEF28, 1'b0, 10'd0, rv, waits);
    chk("wr13A_waits", 32'(waits), 32'd3);
    access(1'b1, 1'b0, 10'h13A, 32'd0, 1'b0, 10'd0, rv, waits);
    chk("rd13A_data", rv, 32'h28);
    chk("wr13A_count", {16'b0, wrc}, 32'd1);
    chk("wr13A_last_addr", {22'b0, lwa}, 32'h13A);

    access(1'b0, 1'b1, 10'h135, 32'hFF, 1'b0, 10'd0, rv, waits);
    access(1'b0, 1'b1, 10'h13A, 32'hFF, 1'b0, 10'd0, rv, waits);
    stream_profile(0);
    access(1'b1, 1'b0, 10'h135, 32'd0, 1'b0, 10'd0, rv, waits);
    chk("prof0_135", rv, 32'hF3);
    access(1'b1, 1'b0, 10'h13A, 32'd0, 1'b0, 10'd0, rv, waits);
    chk("prof0_13A", rv, 32'hEF);
    stream_profile(3);
    access(1'b1, 1'b0, 10'h135, 32'd0, 1'b0, 10'd0, rv, waits);
    chk("prof1_135", rv, 32'hFF);
    access(1'b1, 1'b0, 10'h13A, 32'd0, 1'b0, 10'd0, rv, waits);
    chk("prof1_13A", rv, 32'hE7);
    chk("prof_wr_count", {16'b0, wrc}, 32'd7);
    chk("prof_last_addr", {22'b0, lwa}, 32'h13A);
    chk("prof_prot_err", {31'b0, perr}, 32'd0);

    // Address moves during BUSY: latched address still serviced.
    access(1'b1, 1'b0, 10'h135, 32'd0, 1'b1, 10'h13A, rv, waits);
    chk("addrchg_data", rv, 32'hFF);
    chk("addrchg_prot_err", {31'b0, perr}, 32'd1);

    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    access(1'b0, 1'b1, 10'h135, 32'h5A, 1'b0, 10'd0, rv, waits);
    chk("pre_drop_prot_err", {31'b0, perr}, 32'd0);
    addr = 10'h135; rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
    @(posedge clk); #1;
    chk("droprd_prot_err", {31'b0, perr}, 32'd1);
    chk("droprd_waitreq", {31'b0, wreq}, 32'd1);
    chk("droprd_readdata", rdata, 32'd0);
    wd = 32'h11; wr = 1'b1;
    @(posedge clk); #1 wr = 1'b0;
    @(posedge clk); #1;
    chk("dropwr_count", {16'b0, wrc}, 32'd1);
    access(1'b1, 1'b0, 10'h135, 32'd0, 1'b0, 10'd0, rv, waits);
    chk("drop_reg_unchanged", rv, 32'h5A);

    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    chk("rst2_prot_err", {31'b0, perr}, 32'd0);
    access(1'b1, 1'b1, 10'h040, 32'h77, 1'b0, 10'd0, rv, waits);
    chk("rdwr_waits", 32'(waits), 32'd3);
    chk("rdwr_readdata", rv, 32'd0);
    chk("rdwr_prot_err", {31'b0, perr}, 32'd1);
    chk("rdwr_count", {16'b0, wrc}, 32'd1);
    chk("rdwr_last_addr", {22'b0, lwa}, 32'h040);
    access(1'b1, 1'b0, 10'h040, 32'd0, 1'b0, 10'd0, rv, waits);
    chk("rdwr_reg", rv, 32'h77);

    addr = 10'h041; wd = 32'h33; wr = 1'b1;
    @(posedge clk); #1;
    chk("busy_waitreq", {31'b0, wreq}, 32'd1);
    rst = 1'b1; wr = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    chk("rstbusy_waitreq", {31'b0, wreq}, 32'd1);
    chk("rstbusy_readdata", rdata, 32'd0);
    chk("rstbusy_wr_count", {16'b0, wrc}, 32'd0);
    chk("rstbusy_last_addr", {22'b0, lwa}, 32'd0);
    chk("rstbusy_prot_err", {31'b0, perr}, 32'd0);
    access(1'b1, 1'b0, 10'h040, 32'd0, 1'b0, 10'd0, rv, waits);
    chk("rstbusy_idle_waits", 32'(waits), 32'd3);
    chk("rstbusy_reg_clear", rv, 32'd0);
    access(1'b1, 1'b0, 10'h041, 32'd0, 1'b0, 10'd0, rv, waits);
    chk("rstbusy_no_write", rv, 32'd0);

    a0 = 10'h005; wd0 = 32'h1; w0 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("w0_waitreq_%0d", k), {31'b0, wreq0}, (k % 2 == 1) ? 32'd0 : 32'd1);
      chk($sformatf("w0_count_%0d", k), {16'b0, wrc0}, 32'(k / 2));
    end
    w0 = 1'b0;
    chk("w0_prot_err", {31'b0, perr0}, 32'd0);
    chk("w0_last_addr", {22'b0, lwa0}, 32'h005);

    access0(1'b0, 1'b1, 10'h1FF, 32'h3C, rv);
    chk("w0_1FF_count", {16'b0, wrc0}, 32'd4);
    access0(1'b1, 1'b0, 10'h1FF, 32'd0, rv);
    chk("w0_1FF_data", rv, 32'h3C);
    access0(1'b0, 1'b1, 10'h3FF, 32'h99, rv);
    chk("oor_prot_err", {31'b0, perr0}, 32'd1);
    chk("oor_count", {16'b0, wrc0}, 32'd4);
    chk("oor_last_addr", {22'b0, lwa0}, 32'h1FF);
    access0(1'b1, 1'b0, 10'h1FF, 32'd0, rv);
    chk("oor_no_alias", rv, 32'h3C);
    access0(1'b1, 1'b0, 10'h3FF, 32'd0, rv);
    chk("oor_read_zero", rv, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
